// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle terminal-count pulse.
// A load captures the start value and begins counting down by one per enabled
// clock. On expiry the counter either stops at zero (default) or restarts from
// the last loaded value when COUNTDOWN_AUTORELOAD_EN is defined.
// Reset is synchronous and active-low.

module countdown_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             zero,
   output logic             done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] reload_r;
   logic             busy_r;
   logic             zero_r;
   logic             done_r;

   // Timer FSM: load beats stop, stop beats counting; every output is a register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r  <= IDLE;
         count_r  <= {WIDTH{1'b0}};
         reload_r <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         zero_r   <= 1'b1;
         done_r   <= 1'b0;
      end else if (load) begin
         count_r  <= load_val;
         reload_r <= load_val;
         if (load_val != {WIDTH{1'b0}}) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            zero_r  <= 1'b0;
            done_r  <= 1'b0;
         end else begin
            // A zero load expires immediately.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            zero_r  <= 1'b1;
            done_r  <= 1'b1;
         end
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
            end
            RUN: begin
               if (stop) begin
                  // Abort keeps the current count visible.
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end else if (en) begin
                  if (count_r > WIDTH'(1)) begin
                     count_r <= count_r - WIDTH'(1);
                     zero_r  <= 1'b0;
                     done_r  <= 1'b0;
                  end else if (count_r == WIDTH'(1)) begin
                     done_r <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     // Periodic tick: restart from the captured value.
                     count_r <= reload_r;
                     zero_r  <= (reload_r == {WIDTH{1'b0}});
`else
                     count_r <= {WIDTH{1'b0}};
                     zero_r  <= 1'b1;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
`endif
                  end else begin
                     // RUN never legitimately holds 0; recover to IDLE at the
                     // last loaded value instead of wrapping below zero.
                     count_r <= reload_r;
                     zero_r  <= (reload_r == {WIDTH{1'b0}});
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b0;
                  end
               end else begin
                  done_r <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign count = count_r;
   assign busy  = busy_r;
   assign zero  = zero_r;
   assign done  = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios plus randomized traffic,
// all compared each cycle against a behavioural model of the timer rules.

module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] load_val;
   logic       en;
   logic       stop;
   logic [7:0] count;
   logic       busy;
   logic       zero;
   logic       done;

   int tests_run = 0;
   int tests_failed = 0;

   // Behavioural model state
   int m_count  = 0;
   int m_reload = 0;
   bit m_run    = 1'b0;
   bit m_done   = 1'b0;

`ifdef COUNTDOWN_AUTORELOAD_EN
   localparam bit AUTORELOAD = 1'b1;
`else
   localparam bit AUTORELOAD = 1'b0;
`endif

   countdown_timer #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .stop     (stop),
      .count    (count),
      .busy     (busy),
      .zero     (zero),
      .done     (done)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply the timer rules for one clock edge.
   task automatic model_step(input bit r, input bit ld, input int lv, input bit e, input bit st);
      if (!r) begin
         m_count = 0; m_reload = 0; m_run = 1'b0; m_done = 1'b0;
      end else if (ld) begin
         m_count  = lv;
         m_reload = lv;
         m_run    = (lv != 0);
         m_done   = (lv == 0);
      end else if (m_run && st) begin
         m_run  = 1'b0;
         m_done = 1'b0;
      end else if (m_run && e) begin
         if (m_count == 1) begin
            m_done = 1'b1;
            if (AUTORELOAD) begin
               m_count = m_reload;
            end else begin
               m_count = 0;
               m_run   = 1'b0;
            end
         end else begin
            m_count = m_count - 1;
            m_done  = 1'b0;
         end
      end else begin
         m_done = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, advance the model, compare all outputs.
   task automatic cycle(input bit r, input bit ld, input logic [7:0] lv, input bit e, input bit st);
      reset = r; load = ld; load_val = lv; en = e; stop = st;
      @(posedge clk);
      model_step(r, ld, int'(lv), e, st);
      #1;
      check("count", 32'(count), 32'(m_count));
      check("busy",  32'(busy),  32'(m_run));
      check("zero",  32'(zero),  32'(m_count == 0));
      check("done",  32'(done),  32'(m_done));
   endtask

   initial begin
      int pulses;
      bit e_pat [5];

      // Reset
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_zero",  32'(zero),  32'h1);

      // Load 5, continuous enable: done on the 5th enabled edge
      cycle(1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
      check("ld5_count", 32'(count), 32'h5);
      check("ld5_busy",  32'(busy),  32'h1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("ld5_nodone", 32'(done), 32'h0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("ld5_done", 32'(done), 32'h1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("ld5_single", 32'(done), 32'h0);

      // Load 3 with enable toggling 1,0,1,0,1
      cycle(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
      e_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, e_pat[i], 1'b0);
      check("ld3_done", 32'(done), 32'h1);

      // Load 4, 12 enabled cycles: count done pulses
      cycle(1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
         if (done) pulses++;
      end
      check("ld4_pulses", 32'(pulses), AUTORELOAD ? 32'd3 : 32'd1);

      // Load beats expiry on the same edge
      cycle(1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("pre_exp_count", 32'(count), 32'h1);
      cycle(1'b1, 1'b1, 8'h09, 1'b1, 1'b0);
      check("ldwin_done",  32'(done),  32'h0);
      check("ldwin_count", 32'(count), 32'h9);
      check("ldwin_busy",  32'(busy),  32'h1);

      // Zero load pulses done immediately
      cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
      check("ld0_done", 32'(done), 32'h1);
      check("ld0_busy", 32'(busy), 32'h0);
      check("ld0_zero", 32'(zero), 32'h1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("ld0_single", 32'(done), 32'h0);

      // Stop mid-run at 7
      cycle(1'b1, 1'b1, 8'h09, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      check("stop_count", 32'(count), 32'h7);
      check("stop_busy",  32'(busy),  32'h0);
      check("stop_done",  32'(done),  32'h0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("stop_hold", 32'(count), 32'h7);

      // Reset after random activity
      for (int i = 0; i < 20; i++)
         cycle(1'b1, ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 15)),
               1'($urandom), 1'b0);
      cycle(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("rst2_count", 32'(count), 32'h0);
      check("rst2_busy",  32'(busy),  32'h0);
      check("rst2_zero",  32'(zero),  32'h1);
      check("rst2_done",  32'(done),  32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic [7:0] lv;
         lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
         cycle(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 11) == 0),
               lv,
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable 8-bit down-counter: the decrementing counterpart to the design's free-running up-counter. Software or an FSM loads a start value, and the block counts down by one per enabled clock. It flags terminal count with a single-cycle `done` pulse, then stops or, when configured, reloads. Intended for timeouts and periodic ticks alongside the ALU datapath.

## Interface
- `WIDTH`, 8, counter and load-value width in bits.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `load`  input  1  load request; when sampled high, `load_val` is captured.
- `load_val`  input  WIDTH  start/reload value.
- `en`  input  1  count enable; decrement only when high.
- `stop`  input  1  abort; returns to IDLE, `count` frozen.
- `count`  output  WIDTH  current counter value (registered).
- `busy`  output  1  high in RUN state.
- `zero`  output  1  high when `count == 0` (registered, derived from next count).
- `done`  output  1  one-cycle terminal-count pulse.

## Operation
- Reset (`reset == 0` at edge): `count = 0`, `busy = 0`, `zero = 1`, `done = 0`, reload register = 0, state = IDLE.
- States: IDLE, RUN. All outputs are registered.
- Priority at each edge, highest first: reset, `load`, `stop`, count/expiry.
- `load` (any state):
  - `count <= load_val`; reload register `<= load_val`.
  - If `load_val != 0`, state becomes RUN.
  - If `load_val == 0`, state is IDLE and `done` pulses on that same edge.
- `stop` in RUN (no `load`): state becomes IDLE, `count` held, no `done`.
- RUN with `en == 0`: all state held.
- RUN with `en == 1` and `count > 1`: `count <= count - 1`.
- RUN with `en == 1` and `count == 1` (expiry): `done <= 1` for exactly one cycle; next value per Configuration.
- IDLE without `load`: `count` held, `en` ignored, `done = 0`.
- Load and expiry on the same edge: load wins, no `done` pulse.
- Decrement never underflows. Arithmetic is modulo 2^WIDTH, but 0 is never decremented.

## Timing
- Load latency: `count` reflects `load_val` one cycle after `load` is sampled.
- `busy` rises on the same edge that captures a nonzero `load_val`.
- One-shot mode: a load of N followed by continuous `en` asserts `done` on the Nth enabled edge after load, coincident with `count == 0` and `busy` falling.
- `done` is never asserted for two consecutive cycles, except when reload value = 1 in autoreload mode, where it pulses every enabled cycle.
- Reset mid-count takes effect at the next edge regardless of `load` or `en`.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - On expiry, `count <= reload register`, state stays RUN, `busy` stays 1, `done` pulses.
  - Result is a periodic tick every N enabled cycles.
  - `zero` does not assert on expiry.
- `COUNTDOWN_AUTORELOAD_EN` undefined:
  - On expiry, `count <= 0`, state becomes IDLE, `busy <= 0`, `zero <= 1`.
  - The reload register is still present but is unused after load.

## Test plan
- Reset low for 2 cycles after random activity -> `count=0x00`, `busy=0`, `zero=1`, `done=0`.
- Load `0x05`, `en` held high, autoreload off -> `count` runs 5,4,3,2,1,0; `done` high only on the cycle `count=0`; `busy` low thereafter.
- Load `0x03` with `en` toggling 1,0,1,0,1 -> decrements only on enabled edges; `done` on the third enabled edge.
- Autoreload on, load `0x04`, `en` high for 12 cycles -> `done` pulses every 4 cycles (3 pulses); `count` sequence 4,3,2,1,4,…
- Load `0x02`, then assert `load` with `0x09` on the edge where `count=1` and `en=1` -> no `done`; `count=0x09`, `busy=1`.
- `load_val=0x00` -> `done` pulses once, `busy=0`, `zero=1`; `stop` mid-run at `count=0x07` -> IDLE with `count=0x07`, no `done`.
